// File: rtl/layer_param_arbiter.sv
// ============================================================================
//  Module   : layer_param_arbiter
//  Purpose  : Shares one parameter-memory read port between NUM_REQ layer
//             engines. Bursts are granted one at a time and the read data is
//             routed back to the owner. Build option ARB_FIXED_PRIO_EN selects
//             fixed priority (lowest index wins) instead of round-robin.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module layer_param_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 11,
    parameter int RD_LATENCY = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len,
    output logic                          mem_ren,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    input  logic [DATA_WIDTH-1:0]         mem_rdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          rsp_last,
    output logic                          busy
);

    localparam int c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_BURST = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] c_ONE_ADDR = ADDR_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0]  c_ONE_LEN  = LEN_WIDTH'(1);

    logic [1:0]             r_state;
    logic [1:0]             w_next_state;

    logic [ADDR_WIDTH-1:0]  w_addr_arr [NUM_REQ];
    logic [LEN_WIDTH-1:0]   w_len_arr  [NUM_REQ];

    logic                   w_any;
    logic [c_IDX_W-1:0]     w_win;
    logic                   w_grant;
    logic [ADDR_WIDTH-1:0]  w_win_addr;
    logic [LEN_WIDTH-1:0]   w_win_len;

    logic [c_IDX_W-1:0]     r_id;
    logic [LEN_WIDTH-1:0]   r_len;
    logic [LEN_WIDTH-1:0]   r_cnt;
    logic                   r_mem_ren;
    logic                   r_mem_last;
    logic [ADDR_WIDTH-1:0]  r_mem_addr;

    logic                   r_pv  [RD_LATENCY];
    logic                   r_pl  [RD_LATENCY];
    logic [c_IDX_W-1:0]     r_pid [RD_LATENCY];
    logic                   w_pending;

    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
            assign w_addr_arr[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_len_arr[i]  = req_len[i*LEN_WIDTH +: LEN_WIDTH];
        end
    endgenerate

`ifdef ARB_FIXED_PRIO_EN
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                w_any = 1'b1;
                w_win = c_IDX_W'(k);
            end
        end
    end
`else
    localparam int c_CW = c_IDX_W + 1;

    logic [c_IDX_W-1:0] r_ptr;
    logic [c_CW-1:0]    w_cand;

    // Scan from the pointer upward, wrapping at NUM_REQ; first requester wins.
    always_comb begin
        w_any  = 1'b0;
        w_win  = '0;
        w_cand = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = {1'b0, r_ptr} + c_CW'(k);
            if (w_cand >= c_CW'(NUM_REQ)) begin
                w_cand = w_cand - c_CW'(NUM_REQ);
            end
            if (!w_any && req_valid[w_cand[c_IDX_W-1:0]]) begin
                w_any = 1'b1;
                w_win = w_cand[c_IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_grant) begin
            r_ptr <= (w_win == c_IDX_W'(NUM_REQ - 1)) ? '0 : w_win + c_IDX_W'(1);
        end
    end
`endif

    assign w_grant    = (r_state == c_IDLE) && w_any && !rst;
    assign w_win_addr = w_addr_arr[w_win];
    assign w_win_len  = w_len_arr[w_win];

    // Reads still to come back after this edge; the last stage is leaving now.
    always_comb begin
        w_pending = r_mem_ren;
        for (int i = 0; i < RD_LATENCY - 1; i++) begin
            w_pending = w_pending | r_pv[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_grant && (w_win_len != '0)) begin
                    w_next_state = c_BURST;
                end
            end
            c_BURST: begin
                if (r_cnt == r_len) begin
                    w_next_state = c_DRAIN;
                end
            end
            c_DRAIN: begin
                if (!w_pending) begin
                    w_next_state = c_IDLE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        busy      = (r_state != c_IDLE);
        if (w_grant) begin
            req_ready[w_win] = 1'b1;
        end
    end

    // r_cnt counts reads already placed on the port, including the current one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id       <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_mem_ren  <= 1'b0;
            r_mem_last <= 1'b0;
            r_mem_addr <= '0;
        end else if (w_grant) begin
            r_id       <= w_win;
            r_len      <= w_win_len;
            r_mem_addr <= w_win_addr;
            r_cnt      <= (w_win_len != '0) ? c_ONE_LEN : '0;
            r_mem_ren  <= (w_win_len != '0);
            r_mem_last <= (w_win_len == c_ONE_LEN);
        end else if ((r_state == c_BURST) && (r_cnt != r_len)) begin
            r_mem_ren  <= 1'b1;
            r_mem_addr <= r_mem_addr + c_ONE_ADDR;
            r_cnt      <= r_cnt + c_ONE_LEN;
            r_mem_last <= ((r_cnt + c_ONE_LEN) == r_len);
        end else begin
            r_mem_ren  <= 1'b0;
            r_mem_last <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_pv[i]  <= 1'b0;
                r_pl[i]  <= 1'b0;
                r_pid[i] <= '0;
            end
        end else begin
            r_pv[0]  <= r_mem_ren;
            r_pl[0]  <= r_mem_last;
            r_pid[0] <= r_id;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_pv[i]  <= r_pv[i-1];
                r_pl[i]  <= r_pl[i-1];
                r_pid[i] <= r_pid[i-1];
            end
        end
    end

    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_rsp
            assign rsp_valid[i] = r_pv[RD_LATENCY-1] && (r_pid[RD_LATENCY-1] == c_IDX_W'(i));
        end
    endgenerate

    assign rsp_last = r_pv[RD_LATENCY-1] && r_pl[RD_LATENCY-1];
    assign rsp_data = mem_rdata;
    assign mem_ren  = r_mem_ren;
    assign mem_addr = r_mem_addr;

endmodule

`default_nettype wire

// File: tb/tb_layer_param_arbiter.sv
// ============================================================================
//  Module   : tb_layer_param_arbiter
//  Purpose  : Self-checking bench for layer_param_arbiter with a memory model
//             and a response scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_layer_param_arbiter;

    localparam int N   = 3;
    localparam int AW  = 10;
    localparam int DW  = 32;
    localparam int LW  = 11;
    localparam int LAT = 2;

    typedef struct {
        int            id;
        logic [DW-1:0] data;
        logic          last;
    } rsp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*AW-1:0]   req_addr;
    logic [N*LW-1:0]   req_len;
    logic              mem_ren;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_rdata;
    logic [N-1:0]      rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic              rsp_last;
    logic              busy;

    logic [AW-1:0]     eng_addr [N];
    logic [LW-1:0]     eng_len  [N];

    int                vectors = 0;
    int                errors  = 0;
    int                cyc     = 0;
    int                tb_ptr  = 0;
    int                ren_count = 0;
    int                busy_rise = 0;
    int                last_cyc  = 0;
    int                busy_fall_cyc = 0;
    int                gap_cyc   = 0;
    logic              prev_ren  = 1'b0;
    logic              prev_busy = 1'b0;

    logic [AW-1:0]     exp_addr [$];
    rsp_t              exp_rsp  [$];
    int                issue_cyc [$];

    logic [AW-1:0]     mr_addr [LAT];
    logic              mr_ren  [LAT];

    layer_param_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .RD_LATENCY(LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_len(req_len),
        .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
        return 32'hC0DE_0000 ^ {6'd0, a, 6'd0, a};
    endfunction

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW] = eng_addr[i];
            req_len[i*LW +: LW]  = eng_len[i];
        end
    end

    // Memory model: data for the address presented LAT cycles earlier, noise otherwise.
    always @(posedge clk) begin
        mr_addr[0] <= mem_addr;
        mr_ren[0]  <= mem_ren;
        for (int i = 1; i < LAT; i++) begin
            mr_addr[i] <= mr_addr[i-1];
            mr_ren[i]  <= mr_ren[i-1];
        end
    end

    always_comb begin
        if (mr_ren[LAT-1] === 1'b1) mem_rdata = memf(mr_addr[LAT-1]);
        else                        mem_rdata = 32'(cyc) * 32'h9E37_79B9;
    end

    function automatic int pick(input logic [N-1:0] mask, input int ptr);
`ifdef ARB_FIXED_PRIO_EN
        for (int k = 0; k < N; k++) if (mask[k]) return k;
`else
        for (int k = 0; k < N; k++) if (mask[(ptr + k) % N]) return (ptr + k) % N;
`endif
        return 0;
    endfunction

    task automatic push_burst(input int w);
        logic [AW-1:0] a;
        rsp_t          r;
        for (int k = 0; k < int'(eng_len[w]); k++) begin
            a      = eng_addr[w] + AW'(k);
            r.id   = w;
            r.data = memf(a);
            r.last = (k == int'(eng_len[w]) - 1);
            exp_addr.push_back(a);
            exp_rsp.push_back(r);
        end
    endtask

    // Monitor / scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst !== 1'b0) begin
            prev_ren  <= 1'b0;
            prev_busy <= 1'b0;
        end else begin
            if (busy === 1'b1) begin
                vectors++;
                if (req_ready !== '0) begin
                    errors++;
                    $display("FAIL ready_while_busy got=%b want=%b", req_ready, {N{1'b0}});
                end
            end
            if (busy === 1'b1 && !prev_busy) busy_rise++;
            if (busy === 1'b0 && prev_busy)  busy_fall_cyc = cyc;
            if (mem_ren === 1'b1) begin
                ren_count++;
                vectors++;
                if (!prev_ren) gap_cyc = cyc - last_cyc;
                issue_cyc.push_back(cyc);
                if (exp_addr.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_mem_ren got addr=%h want no read", mem_addr);
                end else begin
                    logic [AW-1:0] ea;
                    ea = exp_addr.pop_front();
                    if (mem_addr !== ea) begin
                        errors++;
                        $display("FAIL mem_addr got=%h want=%h", mem_addr, ea);
                    end
                end
            end
            if (rsp_valid !== '0) begin
                vectors++;
                if (exp_rsp.size() == 0) begin
                    errors++;
                    $display("FAIL stray_rsp got valid=%b want=%b", rsp_valid, {N{1'b0}});
                end else begin
                    rsp_t         e;
                    logic [N-1:0] em;
                    e  = exp_rsp.pop_front();
                    em = '0;
                    em[e.id] = 1'b1;
                    if (rsp_valid !== em || rsp_data !== e.data || rsp_last !== e.last) begin
                        errors++;
                        $display("FAIL rsp got valid=%b data=%h last=%b want valid=%b data=%h last=%b",
                                 rsp_valid, rsp_data, rsp_last, em, e.data, e.last);
                    end
                end
                if (issue_cyc.size() != 0) begin
                    int ic;
                    ic = issue_cyc.pop_front();
                    vectors++;
                    if (cyc - ic != LAT) begin
                        errors++;
                        $display("FAIL rsp_latency got=%0d want=%0d", cyc - ic, LAT);
                    end
                end
                if (rsp_last === 1'b1) last_cyc = cyc;
            end else if (rsp_last !== 1'b0) begin
                vectors++;
                errors++;
                $display("FAIL rsp_last_without_valid got=%b want=0", rsp_last);
            end
            prev_ren  <= (mem_ren === 1'b1);
            prev_busy <= (busy === 1'b1);
        end
    end

    task automatic run_grants(input logic [N-1:0] mask, input int n, input bit keep);
        logic [N-1:0] pend;
        logic [N-1:0] em;
        int           got;
        int           guard;
        int           w;
        pend  = mask;
        got   = 0;
        guard = 0;
        @(negedge clk);
        req_valid = pend;
        while (got < n && pend != '0 && guard < 500) begin
            #1;
            if (req_ready !== '0) begin
                w  = pick(pend, tb_ptr);
                em = '0;
                em[w] = 1'b1;
                vectors++;
                if (req_ready !== em) begin
                    errors++;
                    $display("FAIL grant got=%b want=%b", req_ready, em);
                end
                push_burst(w);
                tb_ptr = (w + 1) % N;
                got++;
                @(posedge clk);
                #1;
                if (!keep) pend[w] = 1'b0;
                req_valid = pend;
            end
            @(negedge clk);
            guard++;
        end
        if (got < n) begin
            vectors++;
            errors++;
            $display("FAIL grant_timeout got=%0d want=%0d", got, n);
        end
        req_valid = '0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            #1;
            guard++;
        end while ((busy !== 1'b0 || exp_rsp.size() != 0) && guard < 300);
        if (guard >= 300) begin
            vectors++;
            errors++;
            $display("FAIL idle_timeout got busy=%b pending=%0d want idle", busy, exp_rsp.size());
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 3'b011;
        repeat (2) @(negedge clk);
        #1;
        vectors += 6;
        if (req_ready !== '0)  begin errors++; $display("FAIL reset_req_ready got=%b want=000", req_ready); end
        if (mem_ren !== 1'b0)  begin errors++; $display("FAIL reset_mem_ren got=%b want=0", mem_ren); end
        if (mem_addr !== '0)   begin errors++; $display("FAIL reset_mem_addr got=%h want=000", mem_addr); end
        if (rsp_valid !== '0)  begin errors++; $display("FAIL reset_rsp_valid got=%b want=000", rsp_valid); end
        if (rsp_last !== 1'b0) begin errors++; $display("FAIL reset_rsp_last got=%b want=0", rsp_last); end
        if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        req_valid = '0;
        rst       = 1'b0;
        tb_ptr    = 0;
    endtask

    task automatic test_single_burst();
        eng_addr[0] = 10'h3F0;
        eng_len[0]  = 11'd4;
        run_grants(3'b001, 1, 1'b0);
        wait_idle();
        vectors++;
        if (busy_fall_cyc !== last_cyc + 1) begin
            errors++;
            $display("FAIL busy_fall got=%0d want=%0d", busy_fall_cyc, last_cyc + 1);
        end
    endtask

    task automatic test_addr_wrap();
        eng_addr[2] = 10'h3FE;
        eng_len[2]  = 11'd4;
        run_grants(3'b100, 1, 1'b0);
        wait_idle();
    endtask

    task automatic test_zero_len();
        int ren_snap;
        int rise_snap;
        ren_snap  = ren_count;
        rise_snap = busy_rise;
        eng_len[1] = 11'd0;
        run_grants(3'b010, 1, 1'b0);
        repeat (4) @(negedge clk);
        #1;
        vectors += 3;
        if (ren_count !== ren_snap)  begin errors++; $display("FAIL zero_len_ren got=%0d want=%0d", ren_count, ren_snap); end
        if (busy_rise !== rise_snap) begin errors++; $display("FAIL zero_len_busy got=%0d want=%0d", busy_rise, rise_snap); end
        if (busy !== 1'b0)           begin errors++; $display("FAIL zero_len_busy_now got=%b want=0", busy); end
        eng_addr[0] = 10'h040; eng_len[0] = 11'd1;
        eng_addr[2] = 10'h080; eng_len[2] = 11'd1;
        run_grants(3'b101, 1, 1'b0);
        wait_idle();
    endtask

    task automatic test_contention();
        for (int i = 0; i < N; i++) begin
            eng_addr[i] = AW'(16 * (i + 1));
            eng_len[i]  = 11'd2;
        end
        run_grants(3'b111, 4, 1'b1);
        wait_idle();
    endtask

    task automatic test_back_to_back();
        eng_addr[1] = 10'h120; eng_len[1] = 11'd3;
        eng_addr[2] = 10'h1A0; eng_len[2] = 11'd2;
        run_grants(3'b110, 2, 1'b0);
        wait_idle();
        vectors++;
        if (gap_cyc !== 2) begin
            errors++;
            $display("FAIL burst_gap got=%0d want=2", gap_cyc);
        end
    endtask

    task automatic test_reset_mid_burst();
        int base;
        int guard;
        eng_addr[1] = 10'h200;
        eng_len[1]  = 11'd8;
        run_grants(3'b010, 1, 1'b0);
        base  = ren_count;
        guard = 0;
        do begin
            @(negedge clk);
            #2;
            guard++;
        end while (ren_count < base + 3 && guard < 50);
        if (guard >= 50) begin
            vectors++;
            errors++;
            $display("FAIL reset_mid_wait got=%0d want=%0d", ren_count - base, 3);
        end
        rst = 1'b1;
        #1;
        vectors += 5;
        if (mem_ren !== 1'b0)  begin errors++; $display("FAIL mid_reset_mem_ren got=%b want=0", mem_ren); end
        if (mem_addr !== '0)   begin errors++; $display("FAIL mid_reset_mem_addr got=%h want=000", mem_addr); end
        if (rsp_valid !== '0)  begin errors++; $display("FAIL mid_reset_rsp_valid got=%b want=000", rsp_valid); end
        if (rsp_last !== 1'b0) begin errors++; $display("FAIL mid_reset_rsp_last got=%b want=0", rsp_last); end
        if (busy !== 1'b0)     begin errors++; $display("FAIL mid_reset_busy got=%b want=0", busy); end
        exp_addr.delete();
        exp_rsp.delete();
        issue_cyc.delete();
        tb_ptr = 0;
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        eng_addr[0] = 10'h300; eng_len[0] = 11'd2;
        eng_addr[1] = 10'h310; eng_len[1] = 11'd2;
        run_grants(3'b011, 1, 1'b0);
        wait_idle();
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        for (int i = 0; i < N; i++) begin
            eng_addr[i] = '0;
            eng_len[i]  = '0;
        end
        test_reset();
        test_single_burst();
        test_addr_wrap();
        test_zero_len();
        test_contention();
        test_back_to_back();
        test_reset_mid_burst();
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
